// File: rtl/vec_cache_wr_tag_buf_array_if.sv
// Bus bundle for the vector cache write-tag buffer: allocate, clean, lookup,
// oldest-entry and status signals. clk/rst stay outside as plain ports.
interface vec_cache_wr_tag_buf_array_if #(
  parameter int ENTRY_NUM = 4,
  parameter int INDEX_W   = 8,
  parameter int TAG_W     = 20,
  parameter int WAY_NUM   = 4
);
  localparam int ID_W  = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;
  localparam int WAY_W = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;
  localparam int CNT_W = $clog2(ENTRY_NUM + 1);

  // Allocation is a valid/ready handshake: an entry is taken on a clock edge
  // where alloc_vld && alloc_rdy; alloc_id names the entry that will be taken.
  // clean_vld is a fire-and-forget request with no ready.
  logic               alloc_vld;
  logic               alloc_rdy;
  logic [INDEX_W-1:0] alloc_index;
  logic [TAG_W-1:0]   alloc_tag;
  logic [WAY_W-1:0]   alloc_way;
  logic [ID_W-1:0]    alloc_id;
  logic               clean_vld;
  logic [ID_W-1:0]    clean_id;
  logic [INDEX_W-1:0] lkp_index;
  logic [TAG_W-1:0]   lkp_tag;
  logic               lkp_hit;
  logic [ID_W-1:0]    lkp_hit_id;
  logic [WAY_W-1:0]   lkp_way;
  logic               lkp_set_conflict;
  logic               oldest_vld;
  logic [ID_W-1:0]    oldest_id;
  logic [INDEX_W-1:0] oldest_index;
  logic [TAG_W-1:0]   oldest_tag;
  logic [WAY_W-1:0]   oldest_way;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               empty;
  logic               clean_err;
  logic               dup_err;

  modport master (
    output alloc_vld, alloc_index, alloc_tag, alloc_way, clean_vld, clean_id,
           lkp_index, lkp_tag,
    input  alloc_rdy, alloc_id, lkp_hit, lkp_hit_id, lkp_way, lkp_set_conflict,
           oldest_vld, oldest_id, oldest_index, oldest_tag, oldest_way,
           count, full, empty, clean_err, dup_err
  );

  modport slave (
    input  alloc_vld, alloc_index, alloc_tag, alloc_way, clean_vld, clean_id,
           lkp_index, lkp_tag,
    output alloc_rdy, alloc_id, lkp_hit, lkp_hit_id, lkp_way, lkp_set_conflict,
           oldest_vld, oldest_id, oldest_index, oldest_tag, oldest_way,
           count, full, empty, clean_err, dup_err
  );
endinterface

// File: rtl/vec_cache_wr_tag_buf_array.sv
// Write-tag buffer: pending fill/evict records with address lookup, set-conflict
// detection and oldest-entry selection via an age matrix.
module vec_cache_wr_tag_buf_array #(
  parameter int ENTRY_NUM = 4,
  parameter int INDEX_W   = 8,
  parameter int TAG_W     = 20,
  parameter int WAY_NUM   = 4
) (
  input logic clk,
  input logic rst,
  vec_cache_wr_tag_buf_array_if.slave bus
);
  localparam int ID_W  = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;
  localparam int WAY_W = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;
  localparam int CNT_W = $clog2(ENTRY_NUM + 1);

  logic [ENTRY_NUM-1:0] valid;
  logic [ENTRY_NUM-1:0] age [ENTRY_NUM];  // age[i][j]=1: i older than j
  logic [INDEX_W-1:0]   idx_q [ENTRY_NUM];
  logic [TAG_W-1:0]     tag_q [ENTRY_NUM];
  logic [WAY_W-1:0]     way_q [ENTRY_NUM];
  logic [CNT_W-1:0]     count_q;
  logic                 clean_err_q;
  logic                 dup_err_q;

  logic                 full_w;
  logic                 alloc_fire;
  logic [ID_W-1:0]      free_id;
  logic                 clean_sel;
  logic                 clean_ok;
  logic [ENTRY_NUM-1:0] alloc_match;
  logic [ENTRY_NUM-1:0] lkp_match;
  logic [ENTRY_NUM-1:0] set_match;
  logic                 hit_w;
  logic [ID_W-1:0]      hit_id_w;
  logic [WAY_W-1:0]     hit_way_w;
  logic                 old_vld_w;
  logic [ID_W-1:0]      old_id_w;
  logic [INDEX_W-1:0]   old_idx_w;
  logic [TAG_W-1:0]     old_tag_w;
  logic [WAY_W-1:0]     old_way_w;
  logic                 is_old;

  assign full_w     = (count_q == CNT_W'(ENTRY_NUM));
  assign alloc_fire = bus.alloc_vld && !full_w;
  assign clean_ok   = bus.clean_vld && clean_sel;

  // Descending scans so the lowest matching id is the one that sticks.
  always_comb begin
    free_id   = '0;
    clean_sel = 1'b0;
    hit_w     = 1'b0;
    hit_id_w  = '0;
    hit_way_w = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      alloc_match[i] = valid[i] && (idx_q[i] == bus.alloc_index) && (tag_q[i] == bus.alloc_tag);
      lkp_match[i]   = valid[i] && (idx_q[i] == bus.lkp_index) && (tag_q[i] == bus.lkp_tag);
      set_match[i]   = valid[i] && (idx_q[i] == bus.lkp_index);
      if (!valid[i]) free_id = ID_W'(i);
      if (bus.clean_id == ID_W'(i)) clean_sel = valid[i];
      if (lkp_match[i]) begin
        hit_w     = 1'b1;
        hit_id_w  = ID_W'(i);
        hit_way_w = way_q[i];
      end
    end
  end

  always_comb begin
    old_vld_w = 1'b0;
    old_id_w  = '0;
    old_idx_w = '0;
    old_tag_w = '0;
    old_way_w = '0;
    is_old    = 1'b0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      is_old = valid[i];
      for (int j = 0; j < ENTRY_NUM; j++) begin
        if (j != i && valid[j] && !age[i][j]) is_old = 1'b0;
      end
      if (is_old) begin
        old_vld_w = 1'b1;
        old_id_w  = ID_W'(i);
        old_idx_w = idx_q[i];
        old_tag_w = tag_q[i];
        old_way_w = way_q[i];
      end
    end
  end

  // The freshly allocated entry is never the one being cleaned: free_id only
  // points at entries that are invalid at the start of the cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid       <= '0;
      count_q     <= '0;
      clean_err_q <= 1'b0;
      dup_err_q   <= 1'b0;
      for (int i = 0; i < ENTRY_NUM; i++) age[i] <= '0;
    end else begin
      clean_err_q <= bus.clean_vld && !clean_sel;
      dup_err_q   <= alloc_fire && (|alloc_match);
      count_q     <= count_q + CNT_W'(alloc_fire) - CNT_W'(clean_ok);
      for (int i = 0; i < ENTRY_NUM; i++) begin
        if (clean_ok && bus.clean_id == ID_W'(i)) valid[i] <= 1'b0;
        if (alloc_fire && free_id == ID_W'(i)) begin
          valid[i] <= 1'b1;
          age[i]   <= '0;
        end else if (alloc_fire) begin
          age[i][free_id] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      idx_q[free_id] <= bus.alloc_index;
      tag_q[free_id] <= bus.alloc_tag;
      way_q[free_id] <= bus.alloc_way;
    end
  end

  assign bus.alloc_rdy        = !full_w;
  assign bus.alloc_id         = free_id;
  assign bus.lkp_hit          = hit_w;
  assign bus.lkp_hit_id       = hit_id_w;
  assign bus.lkp_way          = hit_way_w;
  assign bus.lkp_set_conflict = |set_match;
  assign bus.oldest_vld       = old_vld_w;
  assign bus.oldest_id        = old_id_w;
  assign bus.oldest_index     = old_idx_w;
  assign bus.oldest_tag       = old_tag_w;
  assign bus.oldest_way       = old_way_w;
  assign bus.count            = count_q;
  assign bus.full             = full_w;
  assign bus.empty            = (count_q == '0);
  assign bus.clean_err        = clean_err_q;
  assign bus.dup_err          = dup_err_q;
endmodule

// File: doc/vec_cache_wr_tag_buf_array.md
Name: vec_cache_wr_tag_buf_array

Overview:
Multi-entry write-tag buffer for the vector cache tag pipeline. It holds up to ENTRY_NUM pending line fills/evictions, each stored as an index/tag/way record. Callers can look up any entry by address, detect same-set conflicts and pick the oldest pending entry. It sits between the tag-compare stage, which allocates entries, and the refill/writeback return path, which cleans them by entry id.

Parameters:
ENTRY_NUM, 4, number of buffer entries (>=2)
INDEX_W, 8, cache set index width
TAG_W, 20, tag width
WAY_NUM, 4, cache ways; way field is $clog2(WAY_NUM) bits
ID_W, $clog2(ENTRY_NUM), entry id width (derived)
CNT_W, $clog2(ENTRY_NUM+1), occupancy width (derived)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
alloc_vld  in  1  allocation request
alloc_rdy  out  1  buffer can accept an allocation (= !full)
alloc_index  in  INDEX_W  set index of the new entry
alloc_tag  in  TAG_W  tag of the new entry
alloc_way  in  $clog2(WAY_NUM)  victim way
alloc_id  out  ID_W  entry id that an allocation would take this cycle
clean_vld  in  1  release request
clean_id  in  ID_W  entry to release
lkp_index  in  INDEX_W  lookup index
lkp_tag  in  TAG_W  lookup tag
lkp_hit  out  1  a valid entry matches both index and tag
lkp_hit_id  out  ID_W  lowest matching id; 0 if no hit
lkp_way  out  $clog2(WAY_NUM)  way of the hit entry; 0 if no hit
lkp_set_conflict  out  1  a valid entry has the same index (tag ignored)
oldest_vld  out  1  buffer non-empty
oldest_id  out  ID_W  id of the oldest valid entry
oldest_index / oldest_tag / oldest_way  out  as fields  fields of the oldest entry; 0 when empty
count  out  CNT_W  number of valid entries
full  out  1  count == ENTRY_NUM
empty  out  1  count == 0
clean_err  out  1  registered one-cycle pulse: clean of an invalid entry
dup_err  out  1  registered one-cycle pulse: accepted allocation duplicated a valid index+tag

Behaviour:
- Reset (async, rst=1): all valid bits, age matrix, count, clean_err and dup_err go to 0. Then empty=1, full=0, alloc_rdy=1, oldest_vld=0, lkp_hit=0. Payload registers are not reset; every payload output is gated to 0 while its entry is invalid.
- State: per-entry valid bit and payload; an ENTRY_NUM x ENTRY_NUM age matrix, where bit [i][j]=1 means i is older than j.
- Allocation accepted when alloc_vld && alloc_rdy. alloc_id is combinational: the lowest-numbered invalid entry, computed from valid bits at the start of the cycle. At the clock edge the entry's valid bit is set, its payload is written, and it becomes younger than all entries. An allocation is visible to lookup and count from the next cycle.
- Clean: when clean_vld is set and valid[clean_id]=1, the valid bit clears at the edge. Clean takes effect next cycle. If valid[clean_id]=0, state is unchanged and clean_err pulses the next cycle.
- Simultaneous alloc and clean: both apply at the same edge. The allocation never takes the entry being cleaned that cycle, because the free list reflects the start of the cycle. When full, alloc_rdy stays 0 even if a clean is presented in the same cycle (no bypass). count nets +1-1=0.
- alloc_vld while full: ignored; no state change.
- Lookup is fully combinational over current valid entries and has zero latency. If several entries match, the lowest id is reported. Duplicate allocation is accepted; dup_err pulses the next cycle.
- Oldest: the valid entry whose age row is older than every other valid entry. Combinational.
- count: registered, incremented or decremented at the edge per the accepted alloc/clean; it never wraps.
- Reset asserted mid-operation clears everything immediately. No pending state survives reset.

Test Plan:
- Reset, then 4 back-to-back allocs (index 0x10..0x13, tag 0xABC, way 0..3) -> alloc_id 0,1,2,3; count=4; full=1; alloc_rdy=0; oldest_id=0, oldest_index=0x10.
- Full buffer, alloc_vld=1 with clean_id=2 in the same cycle -> allocation rejected; next cycle count=3; alloc_id=2; the following alloc lands in id 2.
- Entries 0,1 valid; clean_id=0 and alloc in the same cycle -> alloc_id=2; count stays 2; oldest_id becomes 1.
- Entry 1 holds index 0x20 / tag 0x55 / way 3 -> lookup 0x20/0x55 gives lkp_hit=1, lkp_hit_id=1, lkp_way=3. Lookup 0x20/0x56 gives lkp_hit=0, lkp_set_conflict=1.
- clean_id=3 with entry 3 invalid -> clean_err=1 for exactly one cycle; count unchanged. Alloc of an existing index+tag -> dup_err pulse, and lookup reports the lower id.
- Assert rst for one cycle with 3 entries valid -> count=0, empty=1, oldest_vld=0, all lookup outputs 0 in the same cycle.
